// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shared main-memory port arbiter for I-cache fills, D-cache fills and D-cache stores
module mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int BLK_WORDS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ic_miss_req,
  input  logic [ADDR_W-1:0]            ic_miss_addr,
  input  logic                         dc_miss_req,
  input  logic [ADDR_W-1:0]            dc_miss_addr,
  input  logic                         dc_wr_req,
  input  logic [ADDR_W-1:0]            dc_wr_addr,
  input  logic [DATA_W-1:0]            dc_wr_data,
  output logic                         ic_fill_we,
  output logic                         dc_fill_we,
  output logic [$clog2(BLK_WORDS)-1:0] fill_word,
  output logic [DATA_W-1:0]            fill_data,
  output logic                         ic_fill_done,
  output logic                         dc_fill_done,
  output logic                         dc_wr_ack,
  output logic                         mem_en,
  output logic                         mem_wr,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata,
  input  logic                         mem_rvalid,
  output logic                         busy
);

  localparam int WORD_W = $clog2(BLK_WORDS);
  localparam int ISS_W  = WORD_W + 1;
  // Byte offset bits inside one block (2 bytes per word).
  localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(BLK_WORDS * 2 - 1);

  typedef enum logic [1:0] {IDLE, WRITE, FILL_D, FILL_I} state_t;

  state_t              state_q;
  logic [ISS_W-1:0]    iss_q;
  logic [WORD_W-1:0]   rcv_q;
  logic [ADDR_W-1:0]   base_q;
  logic                mem_en_q;
  logic                mem_wr_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                wr_ack_q;

  logic [ADDR_W-1:0]   ic_base;
  logic [ADDR_W-1:0]   dc_base;
  logic [ADDR_W-1:0]   next_rd_addr;
  logic                rcv_last;
  logic                iss_more;

  // Block base addresses and the address of the next pipelined read.
  always_comb begin
    ic_base      = ic_miss_addr & ~BLK_MASK;
    dc_base      = dc_miss_addr & ~BLK_MASK;
    next_rd_addr = base_q + (ADDR_W'(iss_q) << 1);
    rcv_last     = (rcv_q == WORD_W'(BLK_WORDS - 1));
    iss_more     = (iss_q < ISS_W'(BLK_WORDS));
  end

  // Arbitration FSM; the memory request is registered so the first read
  // goes out in the cycle right after the grant edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      iss_q       <= '0;
      rcv_q       <= '0;
      base_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wr_ack_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          mem_en_q <= 1'b0;
          mem_wr_q <= 1'b0;
          wr_ack_q <= 1'b0;
          if (dc_wr_req) begin
            state_q     <= WRITE;
            mem_en_q    <= 1'b1;
            mem_wr_q    <= 1'b1;
            mem_addr_q  <= dc_wr_addr;
            mem_wdata_q <= dc_wr_data;
            wr_ack_q    <= 1'b1;
          end else if (dc_miss_req) begin
            state_q    <= FILL_D;
            base_q     <= dc_base;
            mem_en_q   <= 1'b1;
            mem_addr_q <= dc_base;
            iss_q      <= ISS_W'(1);
          end else if (ic_miss_req) begin
            state_q    <= FILL_I;
            base_q     <= ic_base;
            mem_en_q   <= 1'b1;
            mem_addr_q <= ic_base;
            iss_q      <= ISS_W'(1);
          end
        end
        WRITE: begin
          state_q  <= IDLE;
          mem_en_q <= 1'b0;
          mem_wr_q <= 1'b0;
          wr_ack_q <= 1'b0;
        end
        FILL_D, FILL_I: begin
          if (iss_more) begin
            mem_en_q   <= 1'b1;
            mem_addr_q <= next_rd_addr;
            iss_q      <= iss_q + ISS_W'(1);
          end else begin
            mem_en_q <= 1'b0;
          end
          if (mem_rvalid) begin
            if (rcv_last) begin
              state_q  <= IDLE;
              rcv_q    <= '0;
              iss_q    <= '0;
              mem_en_q <= 1'b0;
            end else begin
              rcv_q <= rcv_q + WORD_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Returned words are steered straight to the cache that owns the fill.
  always_comb begin
    ic_fill_we   = (state_q == FILL_I) && mem_rvalid;
    dc_fill_we   = (state_q == FILL_D) && mem_rvalid;
    ic_fill_done = ic_fill_we && rcv_last;
    dc_fill_done = dc_fill_we && rcv_last;
  end

  assign fill_word = rcv_q;
  assign fill_data = mem_rdata;
  assign dc_wr_ack = wr_ack_q;
  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard testbench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_miss_req, dc_miss_req, dc_wr_req;
  logic [15:0] ic_miss_addr, dc_miss_addr, dc_wr_addr, dc_wr_data;
  logic        ic_fill_we, dc_fill_we, ic_fill_done, dc_fill_done, dc_wr_ack;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic        mem_en, mem_wr, busy;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rvalid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int idle_rv = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .BLK_WORDS(8)) dut (
    .clk(clk), .rst(rst),
    .ic_miss_req(ic_miss_req), .ic_miss_addr(ic_miss_addr),
    .dc_miss_req(dc_miss_req), .dc_miss_addr(dc_miss_addr),
    .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
    .ic_fill_we(ic_fill_we), .dc_fill_we(dc_fill_we),
    .fill_word(fill_word), .fill_data(fill_data),
    .ic_fill_done(ic_fill_done), .dc_fill_done(dc_fill_done),
    .dc_wr_ack(dc_wr_ack),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .busy(busy)
  );

  // 4-cycle fixed-latency memory; read data is a fixed scramble of the address.
  logic [3:0]  pv = '0;
  logic [15:0] pa [4];
  logic        force_rv = 1'b0;
  always @(posedge clk) begin
    pv    <= {pv[2:0], (mem_en === 1'b1) && (mem_wr === 1'b0)};
    pa[0] <= mem_addr;
    pa[1] <= pa[0];
    pa[2] <= pa[1];
    pa[3] <= pa[2];
  end
  assign mem_rvalid = pv[3] | force_rv;
  assign mem_rdata  = pa[3] ^ 16'h5A5A;

  typedef struct packed {logic wr; logic [15:0] addr; logic [15:0] wdata;} mem_ev_t;
  typedef struct packed {logic ic; logic [2:0] word; logic [15:0] data; logic done;} fill_ev_t;
  mem_ev_t  mem_q [$];
  fill_ev_t fill_q [$];
  mem_ev_t  me;
  fill_ev_t fe;

  task automatic push_fill(input logic ic, input logic [15:0] addr);
    logic [15:0] base;
    base = addr & 16'hFFF0;
    for (int i = 0; i < 8; i++) begin
      mem_q.push_back('{wr: 1'b0, addr: base + 16'(2 * i), wdata: 16'h0});
      fill_q.push_back('{ic: ic, word: 3'(i), data: (base + 16'(2 * i)) ^ 16'h5A5A, done: (i == 7)});
    end
  endtask

  // Scoreboard monitor: every memory access and every fill write pops one expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_en === 1'b1) begin
        checks++;
        if (mem_q.size() == 0) begin
          errors++;
          $display("FAIL mem_unexpected got wr=%b addr=%h wdata=%h", mem_wr, mem_addr, mem_wdata);
        end else begin
          me = mem_q.pop_front();
          if (mem_wr !== me.wr || mem_addr !== me.addr || (me.wr && mem_wdata !== me.wdata) || dc_wr_ack !== me.wr) begin
            errors++;
            $display("FAIL mem_access got wr=%b addr=%h wdata=%h ack=%b exp wr=%b addr=%h wdata=%h",
                     mem_wr, mem_addr, mem_wdata, dc_wr_ack, me.wr, me.addr, me.wdata);
          end
        end
      end else if (dc_wr_ack !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL ack_without_write got ack=%b exp 0", dc_wr_ack);
      end
      if (ic_fill_we === 1'b1 || dc_fill_we === 1'b1) begin
        checks++;
        if (fill_q.size() == 0) begin
          errors++;
          $display("FAIL fill_unexpected got ic_we=%b dc_we=%b word=%0d", ic_fill_we, dc_fill_we, fill_word);
        end else begin
          fe = fill_q.pop_front();
          if ({ic_fill_we, dc_fill_we, fill_word, fill_data, ic_fill_done, dc_fill_done} !==
              {fe.ic, !fe.ic, fe.word, fe.data, fe.done & fe.ic, fe.done & !fe.ic}) begin
            errors++;
            $display("FAIL fill_write got ic_we=%b dc_we=%b word=%0d data=%h done=%b%b exp ic=%b word=%0d data=%h done=%b",
                     ic_fill_we, dc_fill_we, fill_word, fill_data, ic_fill_done, dc_fill_done,
                     fe.ic, fe.word, fe.data, fe.done);
          end
        end
      end else if (ic_fill_done !== 1'b0 || dc_fill_done !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL done_without_fill got ic_done=%b dc_done=%b exp 0", ic_fill_done, dc_fill_done);
      end
      if (mem_rvalid === 1'b1 && busy === 1'b0) idle_rv++;
    end
  end

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && mem_q.size() == 0 && fill_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++;
    if ({mem_en, mem_wr} !== 2'b00) begin errors++; $display("FAIL reset_mem got en=%b wr=%b exp 00", mem_en, mem_wr); end
    checks++;
    if ({ic_fill_we, dc_fill_we, ic_fill_done, dc_fill_done, dc_wr_ack} !== 5'b0) begin
      errors++; $display("FAIL reset_pulses got %b exp 00000", {ic_fill_we, dc_fill_we, ic_fill_done, dc_fill_done, dc_wr_ack});
    end
    checks++;
    if (mem_addr !== 16'h0 || fill_word !== 3'd0) begin
      errors++; $display("FAIL reset_addr got addr=%h word=%0d exp 0", mem_addr, fill_word);
    end
  endtask

  task automatic test_ic_fill;
    int t, dcyc;
    bit seen;
    push_fill(1'b1, 16'h1236);
    ic_miss_addr = 16'h1236;
    ic_miss_req  = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 16'h1230) begin
      errors++; $display("FAIL ic_first_read got en=%b addr=%h exp 1 1230", mem_en, mem_addr);
    end
    seen = 1'b0;
    dcyc = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ic_fill_done === 1'b1) begin seen = 1'b1; dcyc = cyc; ic_miss_req = 1'b0; end
    end
    checks++;
    if (!seen || dcyc != t + 11) begin
      errors++; $display("FAIL ic_done_time got seen=%b cyc=%0d exp cyc=%0d", seen, dcyc, t + 11);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ic_busy_after got %b exp 0", busy); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_priority;
    bit seen;
    bit ok;
    push_fill(1'b0, 16'h0040);
    push_fill(1'b1, 16'h2000);
    dc_miss_addr = 16'h0040;
    ic_miss_addr = 16'h2000;
    dc_miss_req  = 1'b1;
    ic_miss_req  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (dc_fill_done === 1'b1) begin seen = 1'b1; dc_miss_req = 1'b0; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL prio_dc_done got none exp pulse"); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL prio_gap_busy got %b exp 0", busy); end
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 16'h2000) begin
      errors++; $display("FAIL prio_ic_start got en=%b addr=%h exp 1 2000", mem_en, mem_addr);
    end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ic_fill_done === 1'b1) begin seen = 1'b1; ic_miss_req = 1'b0; end
    end
    wait_drain(20, ok);
    checks++;
    if (!seen || !ok) begin errors++; $display("FAIL prio_ic_done got seen=%b drained=%b exp 1 1", seen, ok); end
  endtask

  task automatic test_write_first;
    bit seen;
    bit ok;
    mem_q.push_back('{wr: 1'b1, addr: 16'h0102, wdata: 16'hBEEF});
    push_fill(1'b0, 16'h0306);
    dc_wr_addr   = 16'h0102;
    dc_wr_data   = 16'hBEEF;
    dc_wr_req    = 1'b1;
    dc_miss_addr = 16'h0306;
    dc_miss_req  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (dc_wr_ack === 1'b1) begin seen = 1'b1; dc_wr_req = 1'b0; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL wr_ack got none exp pulse"); end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (dc_fill_done === 1'b1) begin seen = 1'b1; dc_miss_req = 1'b0; end
    end
    wait_drain(20, ok);
    checks++;
    if (!seen || !ok) begin errors++; $display("FAIL wr_then_fill got seen=%b drained=%b exp 1 1", seen, ok); end
  endtask

  task automatic test_drop_request;
    bit ok;
    push_fill(1'b1, 16'h0A1C);
    ic_miss_addr = 16'h0A1C;
    ic_miss_req  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ic_miss_req = 1'b0;
    wait_drain(40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL drop_complete got pending mem=%0d fill=%0d exp 0 0", mem_q.size(), fill_q.size()); end
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL drop_regrant got busy=%b exp 0", busy); end
  endtask

  task automatic test_reset_mid_fill;
    int rv0;
    bit ok;
    logic [15:0] base;
    base = 16'h0500;
    for (int i = 0; i < 3; i++) mem_q.push_back('{wr: 1'b0, addr: base + 16'(2 * i), wdata: 16'h0});
    dc_miss_addr = 16'h0504;
    dc_miss_req  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    dc_miss_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || mem_en !== 1'b0) begin
      errors++; $display("FAIL rst_mid_fill got busy=%b en=%b exp 0 0", busy, mem_en);
    end
    rv0 = idle_rv;
    repeat (8) @(negedge clk);
    checks++;
    if (idle_rv - rv0 != 3) begin errors++; $display("FAIL rst_stray_rvalid got %0d exp 3", idle_rv - rv0); end
    push_fill(1'b0, 16'h0504);
    dc_miss_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dc_fill_done === 1'b1) begin dc_miss_req = 1'b0; break; end
    end
    wait_drain(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_refill got pending mem=%0d fill=%0d exp 0 0", mem_q.size(), fill_q.size()); end
  endtask

  task automatic test_idle_rvalid;
    @(negedge clk);
    force_rv = 1'b1;
    #1;
    checks++;
    if ({ic_fill_we, dc_fill_we, ic_fill_done, dc_fill_done} !== 4'b0) begin
      errors++; $display("FAIL idle_rvalid got %b exp 0000", {ic_fill_we, dc_fill_we, ic_fill_done, dc_fill_done});
    end
    @(negedge clk);
    force_rv = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    ic_miss_req = 1'b0; dc_miss_req = 1'b0; dc_wr_req = 1'b0;
    ic_miss_addr = '0; dc_miss_addr = '0; dc_wr_addr = '0; dc_wr_data = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    repeat (6) @(negedge clk);
    mon_en = 1'b1;
    test_ic_fill();
    test_priority();
    test_write_first();
    test_drop_request();
    test_reset_mid_fill();
    test_idle_rvalid();
    checks++;
    if (mem_q.size() != 0 || fill_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover got mem=%0d fill=%0d exp 0 0", mem_q.size(), fill_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got running exp finished");
    $fatal(1);
  end

endmodule
